// File: rtl/dual_sram_access_ctrl_pkg.sv
// Shared types and constants for the dual-SRAM access controller and its pin drivers.
// Pin levels are active-low at the SRAM boundary.
package dual_sram_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic OP_RD        = 1'b0;
  localparam logic OP_WR        = 1'b1;
  localparam int   CS_BIT       = 16;
  localparam logic PIN_ACTIVE   = 1'b0;
  localparam logic PIN_INACTIVE = 1'b1;

  // Down-counter load value: the counter reaches zero in the last strobe cycle.
  function automatic logic [3:0] strobe_load(input int wait_cycles);
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/dual_sram_access_ctrl_if.sv
// Request/response bundle between the upstream state machines and the SRAM controller.
interface dual_sram_access_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic              re;
  logic              we;
  logic [16:0]       addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              busy;

  modport master (output en, re, we, addr, data_in, input data_out, done, busy);
  modport slave  (input en, re, we, addr, data_in, output data_out, done, busy);
endinterface

// File: rtl/dual_sram_access_ctrl_sram_pin_driver.sv
// Per-chip pin driver: turns the controller phase into active-low EN/OE/WE,
// the address pins and the tri-state data bus of one SRAM.
module sram_pin_driver
  import dual_sram_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              sel,
  input  logic              op,
  input  state_e            phase,
  input  logic [15:0]       word_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] rdata
);

  logic active;
  logic strobe;
  logic drive;

  // The chip is owned from SETUP through HOLD; FINISH already releases it.
  always_comb begin
    active   = sel && ((phase == ST_SETUP) || (phase == ST_STROBE) || (phase == ST_HOLD));
    strobe   = active && (phase == ST_STROBE);
    drive    = active && (op == OP_WR);
    ram_en_n = active ? PIN_ACTIVE : PIN_INACTIVE;
    ram_oe_n = (strobe && (op == OP_RD)) ? PIN_ACTIVE : PIN_INACTIVE;
    ram_we_n = (strobe && (op == OP_WR)) ? PIN_ACTIVE : PIN_INACTIVE;
    ram_addr = active ? {{(ADDR_W-16){1'b0}}, word_addr} : '0;
  end

  // Only writes drive the bus, so the FPGA never fights the SRAM while OE is low.
  assign ram_data = drive ? wdata : {DATA_W{1'bz}};
  assign rdata    = ram_data;

endmodule

// File: rtl/dual_sram_access_ctrl.sv
// Sequences single-cycle read/write requests into SETUP/STROBE/HOLD/FINISH pin
// activity on one of two asynchronous SRAMs selected by addr[16].
module dual_sram_access_ctrl
  import dual_sram_access_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  dual_sram_access_ctrl_if.slave bus,
  output logic [ADDR_W-1:0]      ram_addr1,
  output logic [ADDR_W-1:0]      ram_addr2,
  inout  wire  [DATA_W-1:0]      ram_data1,
  inout  wire  [DATA_W-1:0]      ram_data2,
  output logic                   ram1EN,
  output logic                   ram2EN,
  output logic                   ram1OE,
  output logic                   ram2OE,
  output logic                   ram1WE,
  output logic                   ram2WE
);

  localparam logic [3:0] STROBE_LOAD = strobe_load(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [16:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              sel1, sel2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
    end
  end

  // Request payload only matters while the FSM is out of IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.re || bus.we)) begin
          op_d    = bus.we ? OP_WR : OP_RD;
          addr_d  = bus.addr;
          wdata_d = bus.data_in;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = STROBE_LOAD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          // Capture while OE is still low, on the edge that ends the strobe.
          if (op_q == OP_RD) data_out_d = addr_q[CS_BIT] ? rdata2 : rdata1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD:   state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel1         = (addr_q[CS_BIT] == 1'b0);
    sel2         = (addr_q[CS_BIT] == 1'b1);
    bus.done     = (state_q == ST_FINISH);
    bus.busy     = (state_q != ST_IDLE);
    bus.data_out = data_out_q;
  end

  sram_pin_driver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram1 (
    .sel       (sel1),
    .op        (op_q),
    .phase     (state_q),
    .word_addr (addr_q[15:0]),
    .wdata     (wdata_q),
    .ram_en_n  (ram1EN),
    .ram_oe_n  (ram1OE),
    .ram_we_n  (ram1WE),
    .ram_addr  (ram_addr1),
    .ram_data  (ram_data1),
    .rdata     (rdata1)
  );

  sram_pin_driver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram2 (
    .sel       (sel2),
    .op        (op_q),
    .phase     (state_q),
    .word_addr (addr_q[15:0]),
    .wdata     (wdata_q),
    .ram_en_n  (ram2EN),
    .ram_oe_n  (ram2OE),
    .ram_we_n  (ram2WE),
    .ram_addr  (ram_addr2),
    .ram_data  (ram_data2),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_dual_sram_access_ctrl.sv
// Bench for dual_sram_access_ctrl: two builds (WAIT_CYCLES 1 and 3), each with
// behavioural SRAM chips, checked against a transaction-level reference model.
module tb_dual_sram_access_ctrl;

  localparam int W_A = 1;
  localparam int W_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en_r   [2];
  logic        re_r   [2];
  logic        we_r   [2];
  logic [16:0] addr_r [2];
  logic [15:0] din_r  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dual_sram_access_ctrl_if #(.DATA_W(16)) ifc ();
    assign ifc.en      = en_r[g];
    assign ifc.re      = re_r[g];
    assign ifc.we      = we_r[g];
    assign ifc.addr    = addr_r[g];
    assign ifc.data_in = din_r[g];

    wire [17:0] a1, a2;
    wire [15:0] d1, d2;
    wire        e1, e2, o1, o2, w1, w2;

    dual_sram_access_ctrl #(.WAIT_CYCLES(g == 0 ? W_A : W_B), .DATA_W(16), .ADDR_W(18)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .bus       (ifc),
      .ram_addr1 (a1),
      .ram_addr2 (a2),
      .ram_data1 (d1),
      .ram_data2 (d2),
      .ram1EN    (e1),
      .ram2EN    (e2),
      .ram1OE    (o1),
      .ram2OE    (o2),
      .ram1WE    (w1),
      .ram2WE    (w2)
    );

    // Behavioural asynchronous SRAMs: drive the bus while selected with OE low.
    logic [15:0] mem1 [0:65535];
    logic [15:0] mem2 [0:65535];
    assign d1 = (!e1 && !o1) ? mem1[a1[15:0]] : 16'hzzzz;
    assign d2 = (!e2 && !o2) ? mem2[a2[15:0]] : 16'hzzzz;

    // Cumulative pin statistics: 0/1 WE low, 2/3 OE low, 4/5 EN low, 6 done,
    // 7 OE and WE low together, 8 idle chip with nonzero address, 9/10 strobe address.
    int cnt [0:10] = '{default: 0};
    always @(negedge clk) begin
      if (!w1) cnt[0] <= cnt[0] + 1;
      if (!w2) cnt[1] <= cnt[1] + 1;
      if (!o1) cnt[2] <= cnt[2] + 1;
      if (!o2) cnt[3] <= cnt[3] + 1;
      if (!e1) cnt[4] <= cnt[4] + 1;
      if (!e2) cnt[5] <= cnt[5] + 1;
      if (ifc.done) cnt[6] <= cnt[6] + 1;
      if ((!o1 && !w1) || (!o2 && !w2)) cnt[7] <= cnt[7] + 1;
      if ((e1 && a1 != 18'd0) || (e2 && a2 != 18'd0)) cnt[8] <= cnt[8] + 1;
      if (!o1 || !w1) cnt[9] <= int'(a1);
      if (!o2 || !w2) cnt[10] <= int'(a2);
      if (!e1 && !w1) mem1[a1[15:0]] <= d1;
      if (!e2 && !w2) mem2[a2[15:0]] <= d2;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] exp_dout [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mon(input int d, input int i);
    return (d == 1) ? g_dut[1].cnt[i] : g_dut[0].cnt[i];
  endfunction

  function automatic logic [5:0] pins(input int d);
    if (d == 1) return {g_dut[1].e1, g_dut[1].o1, g_dut[1].w1, g_dut[1].e2, g_dut[1].o2, g_dut[1].w2};
    return {g_dut[0].e1, g_dut[0].o1, g_dut[0].w1, g_dut[0].e2, g_dut[0].o2, g_dut[0].w2};
  endfunction

  function automatic logic [35:0] apins(input int d);
    return (d == 1) ? {g_dut[1].a1, g_dut[1].a2} : {g_dut[0].a1, g_dut[0].a2};
  endfunction

  function automatic logic done_f(input int d);
    return (d == 1) ? g_dut[1].ifc.done : g_dut[0].ifc.done;
  endfunction

  function automatic logic busy_f(input int d);
    return (d == 1) ? g_dut[1].ifc.busy : g_dut[0].ifc.busy;
  endfunction

  function automatic logic [15:0] dout_f(input int d);
    return (d == 1) ? g_dut[1].ifc.data_out : g_dut[0].ifc.data_out;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 1) ? W_B : W_A;
  endfunction

  task automatic snap(input int d, output int base [0:10]);
    for (int i = 0; i < 11; i++) base[i] = mon(d, i);
  endtask

  // One accepted transaction, checked end to end against the reference model.
  task automatic xact(input int d, input logic r, input logic w, input logic [16:0] a,
                      input logic [15:0] dat, input string tag);
    int base [0:10];
    int k;
    bit got;
    int sel;
    int oth;
    int wc;
    wc  = wait_of(d);
    sel = a[16] ? 1 : 0;
    oth = 1 - sel;
    snap(d, base);
    @(negedge clk);
    en_r[d] = 1'b1; re_r[d] = r; we_r[d] = w; addr_r[d] = a; din_r[d] = dat;
    @(posedge clk);
    #1;
    re_r[d] = 1'b0; we_r[d] = 1'b0;
    k = 0; got = 1'b0;
    repeat (20) begin
      @(negedge clk);
      k++;
      if (done_f(d)) begin got = 1'b1; break; end
    end
    check({tag, " latency"}, got ? k : -1, 3 + wc);
    if (w) ref_mem[{d[0], a}] = dat;
    else   exp_dout[d] = ref_mem[{d[0], a}];
    @(negedge clk);
    #1;
    check({tag, " done_pulse"}, {31'd0, done_f(d)}, 0);
    check({tag, " busy_idle"}, {31'd0, busy_f(d)}, 0);
    check({tag, " data_out"}, {16'd0, dout_f(d)}, {16'd0, exp_dout[d]});
    check({tag, " done_count"}, mon(d, 6) - base[6], 1);
    check({tag, " we_cycles"}, mon(d, sel) - base[sel], w ? wc : 0);
    check({tag, " oe_cycles"}, mon(d, 2 + sel) - base[2 + sel], w ? 0 : wc);
    check({tag, " en_cycles"}, mon(d, 4 + sel) - base[4 + sel], wc + 2);
    check({tag, " other_chip_idle"}, mon(d, 4 + oth) - base[4 + oth], 0);
    check({tag, " strobe_addr"}, mon(d, 9 + sel), {16'd0, a[15:0]});
    check({tag, " oe_we_overlap"}, mon(d, 7), 0);
    check({tag, " idle_addr"}, mon(d, 8), 0);
  endtask

  initial begin
    int base [0:10];
    logic [16:0] pool [6];
    for (int d = 0; d < 2; d++) begin
      en_r[d] = 1'b1; re_r[d] = 1'b0; we_r[d] = 1'b0; addr_r[d] = '0; din_r[d] = '0;
      exp_dout[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset pins", {26'd0, pins(d)}, 32'h3F);
      check("reset addr", apins(d) == 36'd0 ? 1 : 0, 1);
      check("reset busy", {31'd0, busy_f(d)}, 0);
      check("reset done", {31'd0, done_f(d)}, 0);
      check("reset data_out", {16'd0, dout_f(d)}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    xact(0, 1'b0, 1'b1, 17'h00005, 16'h1234, "wr ram1");
    xact(0, 1'b1, 1'b0, 17'h00005, 16'h0000, "rd ram1");
    xact(0, 1'b0, 1'b1, 17'h10005, 16'hBEEF, "wr ram2");
    xact(0, 1'b1, 1'b0, 17'h00005, 16'h0000, "rd ram1 again");
    xact(0, 1'b1, 1'b0, 17'h10005, 16'h0000, "rd ram2");
    xact(0, 1'b1, 1'b1, 17'h00010, 16'h00AA, "re_we both");
    xact(0, 1'b1, 1'b0, 17'h00010, 16'h0000, "rd after both");

    // Second write two cycles into the first one must be dropped.
    xact(0, 1'b0, 1'b1, 17'h00031, 16'h0C0C, "prefill");
    snap(0, base);
    @(negedge clk);
    we_r[0] = 1'b1; addr_r[0] = 17'h00030; din_r[0] = 16'hAAAA;
    @(posedge clk);
    #1;
    we_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("busy during op", {31'd0, busy_f(0)}, 1);
    we_r[0] = 1'b1; addr_r[0] = 17'h00031; din_r[0] = 16'hBBBB;
    @(posedge clk);
    #1;
    we_r[0] = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("busy ignored done_count", mon(0, 6) - base[6], 1);
    check("busy ignored we_cycles", mon(0, 0) - base[0], W_A);
    ref_mem[{1'b0, 17'h00030}] = 16'hAAAA;
    xact(0, 1'b1, 1'b0, 17'h00031, 16'h0000, "rd not overwritten");
    xact(0, 1'b1, 1'b0, 17'h00030, 16'h0000, "rd first write");

    // Reset in the middle of a write strobe.
    xact(0, 1'b0, 1'b1, 17'h00020, 16'h1111, "pre reset wr");
    snap(0, base);
    @(negedge clk);
    we_r[0] = 1'b1; addr_r[0] = 17'h00020; din_r[0] = 16'h5555;
    @(posedge clk);
    #1;
    we_r[0] = 1'b0;
    @(posedge clk);
    #2;
    check("mid strobe pins", {26'd0, pins(0)}, 32'h17);
    rst_n = 1'b0;
    #1;
    check("async reset pins", {26'd0, pins(0)}, 32'h3F);
    check("async reset addr", apins(0) == 36'd0 ? 1 : 0, 1);
    check("async reset busy", {31'd0, busy_f(0)}, 0);
    check("async reset data_out", {16'd0, dout_f(0)}, 0);
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("reset no done", mon(0, 6) - base[6], 0);
    check("reset no we", mon(0, 0) - base[0], 0);
    xact(0, 1'b1, 1'b0, 17'h00020, 16'h0000, "rd after reset");

    // en low: request ignored, no pin activity.
    snap(0, base);
    @(negedge clk);
    en_r[0] = 1'b0; re_r[0] = 1'b1; addr_r[0] = 17'h00005;
    @(posedge clk);
    #1;
    re_r[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("en low no done", mon(0, 6) - base[6], 0);
    check("en low no en1", mon(0, 4) - base[4], 0);
    check("en low no en2", mon(0, 5) - base[5], 0);
    check("en low busy", {31'd0, busy_f(0)}, 0);
    en_r[0] = 1'b1;

    // Randomized traffic over a small address pool spanning both chips.
    for (int i = 0; i < 6; i++) begin
      pool[i] = {1'($urandom_range(0, 1)), 16'($urandom)};
      xact(0, 1'b0, 1'b1, pool[i], 16'($urandom), "rand fill");
    end
    for (int i = 0; i < 16; i++) begin
      logic is_wr;
      is_wr = 1'($urandom_range(0, 1));
      xact(0, ~is_wr, is_wr, pool[$urandom_range(0, 5)], 16'($urandom), "rand op");
    end

    // Longer strobe build.
    xact(1, 1'b0, 1'b1, 17'h10033, 16'h7777, "w3 wr ram2");
    xact(1, 1'b0, 1'b1, 17'h00033, 16'h3333, "w3 wr ram1");
    xact(1, 1'b1, 1'b0, 17'h10033, 16'h0000, "w3 rd ram2");
    xact(1, 1'b1, 1'b0, 17'h00033, 16'h0000, "w3 rd ram1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
